// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
//   mdu_op_t    : operation encoding, identical to the RV32M funct3 field
//   mdu_state_t : controller states IDLE / CALC / FIX
//   is_div, a_signed, b_signed : operation-class predicates
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  // Division-class operation (quotient or remainder).
  function automatic logic is_div(input mdu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // rs1 is interpreted as two's complement.
  function automatic logic a_signed(input mdu_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is interpreted as two's complement.
  function automatic logic b_signed(input mdu_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Final correction stage of the multiply/divide unit (purely combinational).
// Restores the sign of the unsigned magnitude result, picks the half of the
// product or the quotient/remainder that the operation returns, and applies
// the divide-by-zero and signed-overflow overrides.
//   op     : latched operation
//   acc    : raw datapath result; product, or {remainder, quotient}
//   a_orig : rs1 exactly as latched (returned by REM/REMU on divide by zero)
//   sign_q : negate the product / quotient
//   sign_r : negate the remainder
//   div0   : divisor was zero
//   ovf    : signed MIN / -1 division
//   result : corrected WIDTH-bit result
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_op_t              op,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     a_orig,
  input  logic                 sign_q,
  input  logic                 sign_r,
  input  logic                 div0,
  input  logic                 ovf,
  output logic [WIDTH-1:0]     result
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // The product is negated at full double width so the high half carries
  // the borrow out of the low half correctly.
  assign prod = sign_q ? -acc : acc;
  assign quo  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    result = '0;
    case (op)
      OP_MUL:                       result = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU: begin
        if (div0)     result = ALL_ONES;
        else if (ovf) result = MIN_VAL;
        else          result = quo;
      end
      OP_REM, OP_REMU: begin
        if (div0)     result = a_orig;
        else if (ovf) result = '0;
        else          result = rem;
      end
      default:        result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit for the multicycle datapath.
// Operands are reduced to magnitudes on acceptance, one bit is resolved per
// cycle (shift-add multiply or restoring divide), and a single FIX cycle
// restores the sign and applies the special-case overrides.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   start  : request, honoured only while idle and busy=0
//   funct3 : operation (mdu_op_t encoding)
//   src_a  : rs1 (multiplicand / dividend)
//   src_b  : rs2 (multiplier / divisor)
//   busy   : operation in progress, controller holds EXECUTE
//   done   : one-cycle pulse, result valid
//   result : registered result, held until the next operation completes
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32   // must be >= 4 and even
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_t         state_reg;
  mdu_op_t            op_reg;
  logic [2*WIDTH-1:0] acc_reg;      // product accumulator, or {rem, quo}
  logic [WIDTH-1:0]   opnd_reg;     // |multiplicand| or |divisor|
  logic [WIDTH-1:0]   a_reg;
  logic               sign_q_reg;
  logic               sign_r_reg;
  logic               div0_reg;
  logic               ovf_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   fix_res_reg;
  logic               fix_valid_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   result_reg;

  // ---------------------------------------------------------------------
  // Operand preparation on acceptance
  // ---------------------------------------------------------------------
  mdu_op_t          op_in;
  logic             sa_in;
  logic             sb_in;
  logic [WIDTH-1:0] abs_a_in;
  logic [WIDTH-1:0] abs_b_in;
  logic             accept;

  assign op_in    = mdu_op_t'(funct3);
  assign sa_in    = a_signed(op_in) && src_a[WIDTH-1];
  assign sb_in    = b_signed(op_in) && src_b[WIDTH-1];
  // MIN negates to itself, which is the correct unsigned magnitude.
  assign abs_a_in = sa_in ? -src_a : src_a;
  assign abs_b_in = sb_in ? -src_b : src_b;
  // The state check blocks the cycle right after acceptance, where the
  // registered busy has not risen yet; busy_reg blocks the cycle after FIX.
  assign accept   = start && (state_reg == IDLE) && !busy_reg;

  // ---------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------
  logic [WIDTH:0]     mul_upper;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_step;

  // Shift-add: the multiplier sits in the low half and is consumed LSB
  // first; the carry out of the add re-enters at the top on the shift.
  assign mul_upper = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                     (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_step  = {mul_upper, acc_reg[WIDTH-1:1]};

  // Restoring divide: the partial remainder stays below the divisor, so the
  // shifted value fits WIDTH+1 bits and bit WIDTH of the trial difference
  // is a reliable "went negative" indicator.
  assign rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, opnd_reg};
  assign div_step  = trial[WIDTH] ? {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                  : {trial[WIDTH-1:0],     acc_reg[WIDTH-2:0], 1'b1};

  // ---------------------------------------------------------------------
  // Sign correction / override stage
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] fix_result;

  mdu_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .op     (op_reg),
    .acc    (acc_reg),
    .a_orig (a_reg),
    .sign_q (sign_q_reg),
    .sign_r (sign_r_reg),
    .div0   (div0_reg),
    .ovf    (ovf_reg),
    .result (fix_result)
  );

  // ---------------------------------------------------------------------
  // Controller. busy, done and result are registered one stage behind the
  // state so the controller sees clean flop outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      op_reg        <= OP_MUL;
      acc_reg       <= '0;
      opnd_reg      <= '0;
      a_reg         <= '0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      div0_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      cnt_reg       <= '0;
      fix_res_reg   <= '0;
      fix_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      result_reg    <= '0;
    end else begin
      busy_reg      <= (state_reg != IDLE);
      done_reg      <= fix_valid_reg;
      fix_valid_reg <= 1'b0;
      if (fix_valid_reg) begin
        result_reg <= fix_res_reg;
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg     <= op_in;
            a_reg      <= src_a;
            acc_reg    <= is_div(op_in) ? {{WIDTH{1'b0}}, abs_a_in}
                                        : {{WIDTH{1'b0}}, abs_b_in};
            opnd_reg   <= is_div(op_in) ? abs_b_in : abs_a_in;
            sign_q_reg <= sa_in ^ sb_in;
            sign_r_reg <= sa_in;
            div0_reg   <= (src_b == '0);
            ovf_reg    <= ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                          (src_a == MIN_VAL) && (src_b == '1);
            cnt_reg    <= CNT_LOAD;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          acc_reg <= is_div(op_reg) ? div_step : mul_step;
          cnt_reg <= cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          fix_res_reg   <= fix_result;
          fix_valid_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative (WIDTH=32): directed vectors,
// randomized operations against an arithmetic reference model, start
// handshake corner cases and asynchronous reset during an operation.
module tb_mdu_iterative;

  localparam int W   = 32;
  localparam int LAT = W + 2;   // accepting edge to done edge

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   funct3;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks   = 0;
  int failures = 0;

  mdu_iterative #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference model straight from the RV32M definitions.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint      sa, sb, ub, ps;
    logic [63:0] pu;
    int          ai, bi;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ai = $signed(a);
    bi = $signed(b);
    case (op)
      3'd0: begin ps = sa * sb; return ps[31:0]; end
      3'd1: begin ps = sa * sb; return ps[63:32]; end
      3'd2: begin ps = sa * ub; return ps[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ai / bi);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ai % bi);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(5, 0))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(20, 0));
      default: return 32'($urandom);
    endcase
  endfunction

  // Drives one request (accepted at the next edge) and waits for done.
  // Returns at #1 after the done edge; lat=-1 if done never came.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat, output bit busy_ok);
    @(posedge clk); #1;
    start = 1'b1; funct3 = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); src_a = 32'($urandom); src_b = 32'($urandom);
    busy_ok = 1'b1;
    lat     = -1;
    res     = 'x;
    for (int n = 1; n <= LAT + 20; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n;
        res = result;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    $display("op=%0d a=%h b=%h result=%h latency=%0d", op, a, b, res, lat);
  endtask

  // Directed vectors with hand-computed expectations.
  logic [2:0]   d_op  [13] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd5, 3'd7, 3'd6, 3'd4, 3'd6};
  logic [W-1:0] d_a   [13] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'd5, 32'd5, 32'hFFFF_FFF7, 32'h8000_0000, 32'h8000_0000};
  logic [W-1:0] d_b   [13] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [W-1:0] d_exp [13] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                               32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFF7, 32'h8000_0000, 32'h0};

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; funct3 = 3'd0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (result !== '0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
    reset = 1'b0;
    $display("reset released busy=%b done=%b result=%h", busy, done, result);
  endtask

  task automatic test_directed();
    logic [W-1:0] res;
    int           lat;
    bit           bok;
    for (int i = 0; i < 13; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], res, lat, bok);
      checks++;
      if (res !== d_exp[i]) begin
        failures++;
        $display("FAIL directed[%0d]_result: got %h expected %h", i, res, d_exp[i]);
      end
      checks++;
      if (lat != LAT) begin
        failures++;
        $display("FAIL directed[%0d]_latency: got %0d expected %0d", i, lat, LAT);
      end
      checks++;
      if (!bok) begin
        failures++;
        $display("FAIL directed[%0d]_busy: busy profile wrong, got 0 expected 1 until done", i);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]   op;
    logic [W-1:0] a, b, res, exp;
    int           lat;
    bit           bok;
    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom);
      a   = pick_operand();
      b   = pick_operand();
      exp = model(op, a, b);
      run_op(op, a, b, res, lat, bok);
      checks++;
      if (res !== exp || lat != LAT || !bok) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d busy_ok %0d expected %h lat %0d",
                 i, op, a, b, res, lat, bok, exp, LAT);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] exp;
    int           lat;
    exp = model(3'd0, 32'd1234, 32'd5678);
    lat = -1;
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd0; src_a = 32'd1234; src_b = 32'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= LAT + 20; n++) begin
      @(posedge clk); #1;
      if (n == 4) begin
        start = 1'b1; funct3 = 3'd4; src_a = 32'($urandom); src_b = 32'd3;
      end
      if (n == 5) start = 1'b0;
      if (done === 1'b1) begin lat = n; break; end
    end
    $display("ignore_start result=%h latency=%0d", result, lat);
    checks++;
    if (result !== exp) begin
      failures++;
      $display("FAIL ignore_start_result: got %h expected %h", result, exp);
    end
    checks++;
    if (lat != LAT) begin
      failures++;
      $display("FAIL ignore_start_latency: got %0d expected %0d", lat, LAT);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] first, a2, b2, exp2;
    int           lat, lat2;
    bit           bok, held_ok;
    a2   = 32'($urandom);
    b2   = 32'($urandom_range(1000, 1));
    exp2 = model(3'd6, a2, b2);
    run_op(3'd1, 32'h1234_5678, 32'hFEDC_BA98, first, lat, bok);
    checks++;
    if (first !== model(3'd1, 32'h1234_5678, 32'hFEDC_BA98) || lat != LAT) begin
      failures++;
      $display("FAIL b2b_first: got %h lat %0d expected %h lat %0d", first,
               lat, model(3'd1, 32'h1234_5678, 32'hFEDC_BA98), LAT);
    end
    // Still in the done cycle: the new request is sampled at the next edge.
    start = 1'b1; funct3 = 3'd6; src_a = a2; src_b = b2;
    @(posedge clk); #1;
    start = 1'b0;
    held_ok = 1'b1;
    lat2    = -1;
    for (int n = 1; n <= LAT + 20; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat2 = n; break; end
      if (result !== first) held_ok = 1'b0;
    end
    $display("back_to_back op=6 a=%h b=%h result=%h latency=%0d", a2, b2, result, lat2);
    checks++;
    if (!held_ok) begin
      failures++;
      $display("FAIL b2b_hold: result changed early, expected %h held", first);
    end
    checks++;
    if (lat2 != LAT) begin
      failures++;
      $display("FAIL b2b_latency: got %0d expected %0d", lat2, LAT);
    end
    checks++;
    if (result !== exp2) begin
      failures++;
      $display("FAIL b2b_result: got %h expected %h", result, exp2);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res;
    int           lat;
    bit           bok;
    run_op(3'd0, 32'h0001_2345, 32'd3, res, lat, bok);
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd5; src_a = 32'($urandom); src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy_before_reset: got %b expected 1", busy);
    end
    #2;
    reset = 1'b1;
    #1;
    $display("async reset busy=%b done=%b result=%h", busy, done, result);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b done=%b result=%h expected 0 0 0",
               busy, done, result);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(3'd0, 32'd3, 32'd4, res, lat, bok);
    checks++;
    if (res !== 32'd12 || lat != LAT || !bok) begin
      failures++;
      $display("FAIL post_reset_mul: got %h lat %0d expected %h lat %0d", res, lat, 32'd12, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
